// File: rtl/cpu6_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cpu6_wb_arb
//  Purpose  : Round-robin write-back arbiter between the ALU (requester A)
//             and the LSU (requester B) feeding one register-file write port.
//             A single registered output slot holds the pending write.
//             Grants are made combinationally whenever the slot can accept.
//             Writes to register 0 are consumed without being loaded.
//  Ports    : clk, rst_n           - clock, asynchronous active-low reset
//             a_valid/a_addr/a_data, a_ready - requester A handshake
//             b_valid/b_addr/b_data, b_ready - requester B handshake
//             rf_busy                - register-file port stall
//             rf_wen/rf_waddr/rf_wdata - registered register-file write
//             conflict_cnt           - saturating count of contended cycles
//  Revision : 1.0 - initial release
// ============================================================================
module cpu6_wb_arb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          rf_busy,
  output logic          rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [7:0]    conflict_cnt
);

  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_FULL  = 1'b1;

  localparam logic [0:0] RR_A = 1'b0;
  localparam logic [0:0] RR_B = 1'b1;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic [0:0]    r_state;
  logic [0:0]    r_rr_last;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic [7:0]    r_conflict_cnt;

  logic          w_can_accept;
  logic          w_contend;
  logic          w_grant_a;
  logic          w_grant_b;
  logic          w_grant_any;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_data;

  // Gating with rst_n keeps both readies low while reset is held, even
  // though the slot itself reads as empty during reset.
  assign w_can_accept = rst_n && ((r_state == OUT_EMPTY) || !rf_busy);
  assign w_contend    = w_can_accept && a_valid && b_valid;

  // On contention the requester that did not win last time gets the slot.
  assign w_grant_a   = w_can_accept && a_valid && (!b_valid || (r_rr_last == RR_B));
  assign w_grant_b   = w_can_accept && b_valid && (!a_valid || (r_rr_last == RR_A));
  assign w_grant_any = w_grant_a || w_grant_b;

  assign w_gnt_addr = w_grant_b ? b_addr : a_addr;
  assign w_gnt_data = w_grant_b ? b_data : a_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= OUT_EMPTY;
      r_rr_last      <= RR_B;
      r_waddr        <= '0;
      r_wdata        <= '0;
      r_conflict_cnt <= '0;
    end else begin
      // When the slot cannot accept, everything in it holds.  Otherwise the
      // current write (if any) completes this edge and the slot either takes
      // the new grant or drains.  A register-0 grant is consumed but leaves
      // the slot empty, and address/data keep their last values.
      if (w_can_accept) begin
        if (w_grant_any && (w_gnt_addr != '0)) begin
          r_state <= OUT_FULL;
          r_waddr <= w_gnt_addr;
          r_wdata <= w_gnt_data;
        end else begin
          r_state <= OUT_EMPTY;
        end
      end

      if (w_grant_any) begin
        r_rr_last <= w_grant_b ? RR_B : RR_A;
      end

      if (w_contend && (r_conflict_cnt != CNT_MAX)) begin
        r_conflict_cnt <= r_conflict_cnt + 8'd1;
      end
    end
  end

  assign a_ready      = w_grant_a;
  assign b_ready      = w_grant_b;
  assign rf_wen       = (r_state == OUT_FULL);
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu6_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu6_wb_arb
//  Purpose  : Self-checking bench for cpu6_wb_arb.  Directed steps drive the
//             requesters; every write the bench expects to reach the
//             register file is queued and matched against completed writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu6_wb_arb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          rf_busy;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [7:0]    conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW+DW-1:0] exp_q[$];

  cpu6_wb_arb #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .rf_busy      (rf_busy),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // A write completes on an edge where rf_wen=1 and rf_busy=0; sample just
  // before that edge and match against the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && rf_wen && !rf_busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'({rf_waddr, rf_wdata}), 64'd0);
      end else begin
        check("sb_write", 64'({rf_waddr, rf_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  logic exp_a;

  initial begin
    rst_n = 1'b0; rf_busy = 1'b0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA1;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB2;
    repeat (2) @(posedge clk);
    #4;
    check("rst_wen",   64'(rf_wen),       64'd0);
    check("rst_waddr", 64'(rf_waddr),     64'd0);
    check("rst_wdata", 64'(rf_wdata),     64'd0);
    check("rst_cnt",   64'(conflict_cnt), 64'd0);
    check("rst_a_rdy", 64'(a_ready),      64'd0);
    check("rst_b_rdy", 64'(b_ready),      64'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Contention straight after reset: A, B, A with both held.
    cyc(); a_valid = 1'b1; b_valid = 1'b1; #3;
    check("c1_a_rdy", 64'(a_ready), 64'd1);
    check("c1_b_rdy", 64'(b_ready), 64'd0);
    check("c1_cnt",   64'(conflict_cnt), 64'd0);
    push(5'd1, 32'hA1);
    cyc(); #3;
    check("c2_a_rdy", 64'(a_ready), 64'd0);
    check("c2_b_rdy", 64'(b_ready), 64'd1);
    check("c2_wen",   64'(rf_wen), 64'd1);
    check("c2_waddr", 64'(rf_waddr), 64'd1);
    check("c2_cnt",   64'(conflict_cnt), 64'd1);
    push(5'd2, 32'hB2);
    cyc(); #3;
    check("c3_a_rdy", 64'(a_ready), 64'd1);
    check("c3_b_rdy", 64'(b_ready), 64'd0);
    check("c3_waddr", 64'(rf_waddr), 64'd2);
    check("c3_cnt",   64'(conflict_cnt), 64'd2);
    push(5'd1, 32'hA1);
    cyc(); a_valid = 1'b0; b_valid = 1'b0; #3;
    check("c4_waddr", 64'(rf_waddr), 64'd1);
    check("c4_cnt",   64'(conflict_cnt), 64'd3);
    check("c4_a_rdy", 64'(a_ready), 64'd0);
    cyc(); #3;
    check("c5_wen", 64'(rf_wen), 64'd0);

    // Single requester A.
    cyc(); a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11; #3;
    check("sa_a_rdy", 64'(a_ready), 64'd1);
    check("sa_b_rdy", 64'(b_ready), 64'd0);
    push(5'd3, 32'h11);
    cyc(); a_valid = 1'b0; #3;
    check("sa_wen",   64'(rf_wen), 64'd1);
    check("sa_waddr", 64'(rf_waddr), 64'd3);
    check("sa_wdata", 64'(rf_wdata), 64'h11);
    cyc(); #3;
    check("sa_wen_off", 64'(rf_wen), 64'd0);
    check("sa_hold",    64'(rf_waddr), 64'd3);

    // Backpressure: slot full with addr 4, B waits while rf_busy.
    cyc(); a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44; #3;
    check("bp_a_rdy", 64'(a_ready), 64'd1);
    push(5'd4, 32'h44);
    cyc(); a_valid = 1'b0; rf_busy = 1'b1; b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("bp_b_rdy", 64'(b_ready), 64'd0);
      check("bp_wen",   64'(rf_wen), 64'd1);
      check("bp_waddr", 64'(rf_waddr), 64'd4);
      cyc();
    end
    rf_busy = 1'b0; #3;
    check("bp_rel_b_rdy", 64'(b_ready), 64'd1);
    push(5'd9, 32'h99);
    cyc(); b_valid = 1'b0; #3;
    check("bp_new_wen",   64'(rf_wen), 64'd1);
    check("bp_new_waddr", 64'(rf_waddr), 64'd9);
    check("bp_new_wdata", 64'(rf_wdata), 64'h99);
    cyc(); #3;
    check("bp_drain", 64'(rf_wen), 64'd0);

    // rf_busy has no effect while the slot is empty.
    cyc(); rf_busy = 1'b1; a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h55; #3;
    check("ebusy_a_rdy", 64'(a_ready), 64'd1);
    push(5'd5, 32'h55);
    cyc(); rf_busy = 1'b0; a_valid = 1'b0; #3;
    check("ebusy_wen",   64'(rf_wen), 64'd1);
    check("ebusy_waddr", 64'(rf_waddr), 64'd5);
    cyc(); #3;
    check("ebusy_drain", 64'(rf_wen), 64'd0);

    // Register 0 is consumed but never written.
    cyc(); b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h77; #3;
    check("z_b_rdy", 64'(b_ready), 64'd1);
    cyc(); b_valid = 1'b0; #3;
    check("z_wen",   64'(rf_wen), 64'd0);
    check("z_waddr", 64'(rf_waddr), 64'd5);

    // 300 contended cycles to register 0: alternating grants, count saturates.
    exp_a = 1'b1;
    cyc(); a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd0; b_addr = 5'd0;
    for (int i = 0; i < 300; i++) begin
      #3;
      check("sat_a_rdy", 64'(a_ready), 64'(exp_a));
      check("sat_b_rdy", 64'(b_ready), 64'(!exp_a));
      exp_a = !exp_a;
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0; #3;
    check("sat_cnt", 64'(conflict_cnt), 64'd255);
    check("sat_wen", 64'(rf_wen), 64'd0);

    // Fresh reset, then build rf_wen=1 with conflict_cnt=7.
    cyc(); rst_n = 1'b0; exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd0; b_addr = 5'd0;
    exp_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3;
      check("m_a_rdy", 64'(a_ready), 64'(exp_a));
      exp_a = !exp_a;
      cyc();
    end
    a_addr = 5'd6; a_data = 32'h66; b_addr = 5'd8; b_data = 32'h88; #3;
    check("m7_a_rdy", 64'(a_ready), 64'd1);
    check("m7_cnt",   64'(conflict_cnt), 64'd6);
    push(5'd6, 32'h66);
    cyc(); a_valid = 1'b0; b_valid = 1'b0; #3;
    check("m8_wen",   64'(rf_wen), 64'd1);
    check("m8_cnt",   64'(conflict_cnt), 64'd7);
    check("m8_waddr", 64'(rf_waddr), 64'd6);
    // Asynchronous reset in the middle of a pending write.
    a_valid = 1'b1; b_valid = 1'b1; a_addr = 5'd1; b_addr = 5'd2;
    a_data = 32'hA1; b_data = 32'hB2;
    rst_n = 1'b0; exp_q.delete(); #1;
    check("ar_wen",   64'(rf_wen), 64'd0);
    check("ar_waddr", 64'(rf_waddr), 64'd0);
    check("ar_wdata", 64'(rf_wdata), 64'd0);
    check("ar_cnt",   64'(conflict_cnt), 64'd0);
    check("ar_a_rdy", 64'(a_ready), 64'd0);
    check("ar_b_rdy", 64'(b_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1; #3;
    check("ar_first_a", 64'(a_ready), 64'd1);
    check("ar_first_b", 64'(b_ready), 64'd0);
    push(5'd1, 32'hA1);
    cyc(); a_valid = 1'b0; b_valid = 1'b0; #3;
    check("ar_waddr1", 64'(rf_waddr), 64'd1);
    check("ar_cnt1",   64'(conflict_cnt), 64'd1);
    cyc(); #3;
    check("ar_drain", 64'(rf_wen), 64'd0);

    cyc();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu6_wb_arb.md
CPU6_WB_ARB -- requirements
Module: cpu6_wb_arb

Interface
REQ-001 SHALL have parameter DW, default 32, write data width.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports a_valid (input, 1), a_addr (input, AW), a_data (input, DW): requester A (ALU) write request.
REQ-006 SHALL have port a_ready, output, 1: A's request accepted this cycle.
REQ-007 SHALL have ports b_valid (input, 1), b_addr (input, AW), b_data (input, DW): requester B (LSU) write request.
REQ-008 SHALL have port b_ready, output, 1: B's request accepted this cycle.
REQ-009 SHALL have port rf_busy, input, 1: register-file write port cannot take a write this cycle.
REQ-010 SHALL have ports rf_wen (output, 1), rf_waddr (output, AW), rf_wdata (output, DW): registered write to the register file; a write completes on any cycle with rf_wen=1 and rf_busy=0.
REQ-011 SHALL have port conflict_cnt, output, 8: saturating count of contended cycles.

Function
REQ-012 SHALL hold output state OUT_EMPTY (rf_wen=0) or OUT_FULL (rf_wen=1).
REQ-013 SHALL define "can_accept" = OUT_EMPTY, or OUT_FULL with rf_busy=0.
REQ-014 SHALL, when can_accept=0, drive a_ready=0 and b_ready=0 and hold rf_wen/rf_waddr/rf_wdata unchanged.
REQ-015 SHALL, when can_accept=1 and exactly one requester is valid, assert that requester's ready combinationally in the same cycle.
REQ-016 SHALL, when can_accept=1 and both are valid, grant the requester not granted most recently (rr_last); the other ready stays 0.
REQ-017 SHALL update rr_last to the granted requester on every grant; rr_last unchanged on cycles without a grant.
REQ-018 SHALL never assert a_ready and b_ready in the same cycle; ready SHALL never assert for a requester whose valid is 0.
REQ-019 SHALL, on a grant, load rf_waddr/rf_wdata from the granted requester on the next edge and set rf_wen=1 (latency 1 cycle from accept to rf_wen).
REQ-020 SHALL, on a grant whose address is 0, consume the request (ready=1) but not load the output; state becomes OUT_EMPTY if the current write completes, else unchanged.
REQ-021 SHALL, in OUT_FULL with rf_busy=0 and no new grant, return to OUT_EMPTY next cycle (rf_wen=0, addr/data hold last value).
REQ-022 SHALL, in OUT_FULL with rf_busy=0 and a new grant, stay OUT_FULL and load the new write back-to-back (one write per cycle sustained).
REQ-023 SHALL ignore rf_busy in OUT_EMPTY.
REQ-024 SHALL increment conflict_cnt by 1 on each cycle with a_valid=1, b_valid=1 and can_accept=1; saturate at 255 with no wrap.
REQ-025 SHALL not require requesters to hold valid; a dropped valid without ready is simply not accepted.

Reset
REQ-026 SHALL, while rst_n=0 (asynchronous assertion, including mid-write), force rf_wen=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0, rr_last=B (so A wins first contention), state OUT_EMPTY.
REQ-027 SHALL drive a_ready=0 and b_ready=0 while rst_n=0.
REQ-028 SHALL accept requests on the first rising edge after rst_n deasserts.

Verification
REQ-029 Single A: a_valid=1, a_addr=3, a_data=0x11, rf_busy=0 -> a_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=0x11; following cycle rf_wen=0.
REQ-030 Contention after reset: A(addr 1) and B(addr 2) valid for 3 cycles -> grants A, B, A; rf_waddr 1,2,1 on consecutive cycles; conflict_cnt=2 (third cycle: B not valid after grant, test drops it) or 3 if both held.
REQ-031 Backpressure: output full addr 4, rf_busy=1 for 3 cycles with B valid -> b_ready=0 throughout, rf_waddr held at 4; first cycle rf_busy=0 -> b_ready=1, next cycle rf_waddr=B address.
REQ-032 Zero register: B valid, b_addr=0 in OUT_EMPTY -> b_ready=1, rf_wen stays 0 next cycle.
REQ-033 Saturation: 300 contended cycles -> conflict_cnt=255, no wrap.
REQ-034 Reset mid-operation: rst_n low while rf_wen=1, conflict_cnt=7 -> immediately rf_wen=0, conflict_cnt=0, readies 0; after release, A wins first contention.
